// File: rtl/div_seq_8.sv
// div_seq_8: sequential unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   start          request, sampled only when not busy (IDLE or DONE)
//   A, B           dividend / divisor, captured on an accepted start
//   q, r           quotient / remainder, hold the last result
//   busy           high while the N iterations run
//   done           one-cycle pulse when q, r, div_zero become valid
//   div_zero       latched divisor was zero; holds with q and r
module div_seq_8 #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         busy,
    output logic         done,
    output logic         div_zero
);

    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
    logic [N-1:0]  dvs_q, dvs_d;     // latched divisor
    logic [N:0]    p_q, p_d;         // partial remainder, one bit wider than operands
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  r_q, r_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dz_q, dz_d;

    // One restoring step, evaluated from the current registers
    logic [N:0]    p_shift;
    logic          q_bit;
    logic [N:0]    p_next;
    logic [N-1:0]  dvd_next;

    always_comb begin
        p_shift  = {p_q[N-1:0], dvd_q[N-1]};
        q_bit    = (p_shift >= {1'b0, dvs_q});
        p_next   = q_bit ? (p_shift - {1'b0, dvs_q}) : p_shift;
        dvd_next = {dvd_q[N-2:0], q_bit};
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (start) begin
                    dvd_d   = A;
                    dvs_d   = B;
                    p_d     = '0;
                    cnt_d   = CW'(N - 1);
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                p_d   = p_next;
                dvd_d = dvd_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    q_d     = dvd_next;
                    r_d     = p_next[N-1:0];
                    dz_d    = (dvs_q == '0);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign q        = q_q;
    assign r        = r_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_div_seq_8.sv
// tb_div_seq_8: directed and random checks of div_seq_8 against a
// cycle-level behavioural model (integer division plus a latency counter).
module tb_div_seq_8;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic [N-1:0] q, r;
    logic         busy, done, div_zero;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    div_seq_8 dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .q(q), .r(r), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: result = integer division, appears N+1 edges after accept
    int m_left = 0;
    int m_q = 0, m_r = 0, m_dz = 0, m_done = 0;
    int p_q = 0, p_r = 0, p_dz = 0;
    int m_a = 0, m_b = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0; m_done = 0; m_q = 0; m_r = 0; m_dz = 0;
        end else if (m_left > 0) begin
            m_left--;
            m_done = 0;
            if (m_left == 0) begin
                m_done = 1; m_q = p_q; m_r = p_r; m_dz = p_dz;
            end
        end else begin
            m_done = 0;
            if (start) begin
                m_a = int'(A);
                m_b = int'(B);
                if (m_b == 0) begin
                    p_q = 255; p_r = m_a; p_dz = 1;
                end else begin
                    p_q = m_a / m_b; p_r = m_a % m_b; p_dz = 0;
                end
                m_left = N;
            end
        end
    end

    // Cycle-by-cycle comparison, just after the edge settles
    always @(posedge clk) begin
        #1;
        check("busy", int'(busy), (m_left > 0) ? 1 : 0);
        check("done", int'(done), m_done);
        check("q", int'(q), m_q);
        check("r", int'(r), m_r);
        check("div_zero", int'(div_zero), m_dz);
        if (done) begin
            done_cnt++;
            if (m_b != 0) begin
                check("identity q*B+r", int'(q) * m_b + int'(r), m_a);
                check("r<B", (int'(r) < m_b) ? 1 : 0, 1);
            end
        end
    end

    // Wait for done; start is dropped on the first cycle. lat = 0 on timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            n_tests++; n_fail++;
            $display("FAIL timeout waiting for done (t=%0t)", $time);
        end
    endtask

    task automatic do_div(input int a, input int b, input int eq, input int er, input int edz);
        int lat;
        @(negedge clk);
        A = N'(a); B = N'(b); start = 1'b1;
        wait_done(lat);
        check("latency", lat, 9);
        check("lit_q", int'(q), eq);
        check("lit_r", int'(r), er);
        check("lit_dz", int'(div_zero), edz);
    endtask

    initial begin
        int lat, d0, bsy;
        repeat (2) @(negedge clk);
        check("rst_q", int'(q), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;

        // 200/7 with busy-width check
        @(negedge clk);
        A = 8'd200; B = 8'd7; start = 1'b1;
        bsy = 0; lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            A = 8'd3;                  // post-accept operand changes must be ignored
            if (busy) bsy++;
            if (done) begin lat = i; break; end
        end
        check("lat_200_7", lat, 9);
        check("busy_cycles", bsy, 8);
        check("q_200_7", int'(q), 28);
        check("r_200_7", int'(r), 4);

        do_div(13, 200, 0, 13, 0);
        do_div(255, 1, 255, 0, 0);
        do_div(0, 9, 0, 0, 0);
        do_div(77, 0, 255, 77, 1);
        do_div(100, 10, 10, 0, 0);

        // start while busy is ignored
        d0 = done_cnt;
        @(negedge clk);
        A = 8'd100; B = 8'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        A = 8'd50; B = 8'd5; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (12) @(negedge clk);
        check("busy_start_q", int'(q), 33);
        check("busy_start_r", int'(r), 1);
        check("one_done", done_cnt - d0, 1);

        // back-to-back with start held
        @(negedge clk);
        A = 8'd250; B = 8'd16; start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin lat = i; break; end
        end
        check("b2b_q1", int'(q), 15);
        check("b2b_r1", int'(r), 10);
        A = 8'd99; B = 8'd9;       // start still high through the DONE cycle
        wait_done(lat);
        check("b2b_spacing", lat, 9);
        check("b2b_q2", int'(q), 11);
        check("b2b_r2", int'(r), 0);

        // reset mid-run discards the result
        d0 = done_cnt;
        @(negedge clk);
        A = 8'd180; B = 8'd11; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_q", int'(q), 0);
        check("rst_mid_r", int'(r), 0);
        repeat (12) @(negedge clk);
        check("rst_no_done", done_cnt - d0, 0);
        do_div(180, 11, 16, 4, 0);

        // random operands, nonzero divisor
        for (int k = 0; k < 1000; k++) begin
            int a, b;
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(1, 255));
            do_div(a, b, a / b, a % b, 0);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
